// File: rtl/aes_prng_reseed_sched_pkg.sv
// aes_prng_reseed_sched_pkg: shared types and constants for the masking PRNG reseed scheduler
package aes_prng_reseed_sched_pkg;
  typedef enum logic [2:0] {
    PRNG_SCHED_IDLE = 3'b011,
    PRNG_SCHED_REQ  = 3'b101
  } aes_prng_sched_e;
  localparam logic [15:0] PrngReseedRateDefault = 16'd8192;
endpackage

// File: rtl/aes_prng_reseed_sched.sv
// aes_prng_reseed_sched: counts PRNG updates, schedules automatic/software reseeds and runs the req/ack handshake
module aes_prng_reseed_sched #(
  parameter int CntWidth      = 16,
  parameter int NumReseedCntW = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [CntWidth-1:0]      rate_i,
  input  logic                     sw_reseed_i,
  input  logic                     prng_update_i,
  output logic                     reseed_req_o,
  input  logic                     reseed_ack_i,
  output logic                     busy_o,
  output logic                     sw_done_o,
  output logic [NumReseedCntW-1:0] reseed_cnt_o,
  output logic                     ack_err_o
);
  import aes_prng_reseed_sched_pkg::*;
  aes_prng_sched_e state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [CntWidth:0] cnt_inc;
  logic [NumReseedCntW-1:0] reseed_cnt_q, reseed_cnt_d;
  logic sw_pend_q, sw_pend_d, auto_pend_q, auto_pend_d, serve_sw_q, serve_sw_d;
  logic sw_done_q, sw_done_d, ack_err_q, ack_err_d;
  logic in_req, ack, rate_nz, auto_fire, start;
  always_comb begin
    in_req    = state_q == PRNG_SCHED_REQ;
    ack       = in_req & reseed_ack_i;
    rate_nz   = |rate_i;
    cnt_inc   = {1'b0, cnt_q} + {{CntWidth{1'b0}}, 1'b1};
    auto_fire = prng_update_i & rate_nz & (cnt_inc >= {1'b0, rate_i});
    start     = !in_req & (sw_reseed_i | sw_pend_q | auto_pend_q | auto_fire);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= PRNG_SCHED_IDLE;
    else       state_q <= state_d;
  end
  always_comb state_d = ack ? PRNG_SCHED_IDLE : start ? PRNG_SCHED_REQ : state_q;
  // A pending sw request is consumed on entry to REQ; one arriving during REQ forces a fresh reseed.
  always_comb begin
    cnt_d        = (ack | auto_fire) ? '0 : (prng_update_i & rate_nz) ? cnt_inc[CntWidth-1:0] : cnt_q;
    auto_pend_d  = !ack & (auto_pend_q | auto_fire);
    sw_pend_d    = in_req & (sw_pend_q | sw_reseed_i);
    serve_sw_d   = start ? (sw_reseed_i | sw_pend_q) : (serve_sw_q & !ack);
    sw_done_d    = ack & serve_sw_q;
    reseed_cnt_d = reseed_cnt_q + NumReseedCntW'(ack & ~&reseed_cnt_q);
    ack_err_d    = ack_err_q | (reseed_ack_i & !in_req);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      auto_pend_q  <= 1'b0;
      sw_pend_q    <= 1'b0;
      serve_sw_q   <= 1'b0;
      sw_done_q    <= 1'b0;
      reseed_cnt_q <= '0;
      ack_err_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      auto_pend_q  <= auto_pend_d;
      sw_pend_q    <= sw_pend_d;
      serve_sw_q   <= serve_sw_d;
      sw_done_q    <= sw_done_d;
      reseed_cnt_q <= reseed_cnt_d;
      ack_err_q    <= ack_err_d;
    end
  end
  always_comb begin
    reseed_req_o = in_req;
    busy_o       = in_req | sw_pend_q | auto_pend_q;
    sw_done_o    = sw_done_q;
    reseed_cnt_o = reseed_cnt_q;
    ack_err_o    = ack_err_q;
  end
endmodule

// File: tb/tb_aes_prng_reseed_sched.sv
// tb_aes_prng_reseed_sched: randomized scoreboard bench against an event-level reference model
module tb_aes_prng_reseed_sched;
  localparam int CW = 16;
  localparam int NW = 3;
  localparam int CMAX = (1 << NW) - 1;
  logic clk = 1'b0;
  logic rst, sw, upd, ack;
  logic [CW-1:0] rate;
  logic req_o, busy_o, done_o, err_o;
  logic [NW-1:0] cnt_o;
  typedef struct {
    bit req;
    bit busy;
    bit done;
    bit err;
    int cnt;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;
  bit m_req, m_srv, m_swp, m_aup, m_err;
  int m_upd, m_cnt;
  int rates[6] = '{0, 1, 2, 3, 4, 9};

  aes_prng_reseed_sched #(.CntWidth(CW), .NumReseedCntW(NW)) dut (
    .clk_i(clk), .rst_i(rst), .rate_i(rate), .sw_reseed_i(sw), .prng_update_i(upd),
    .reseed_req_o(req_o), .reseed_ack_i(ack), .busy_o(busy_o), .sw_done_o(done_o),
    .reseed_cnt_o(cnt_o), .ack_err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one call per clock edge, applying the scheduling rules to the driven inputs.
  task automatic step();
    bit acc, fire, want;
    exp_t e;
    e.done = 1'b0;
    if (rst) begin
      m_req = 0; m_srv = 0; m_swp = 0; m_aup = 0; m_err = 0; m_upd = 0; m_cnt = 0;
    end else begin
      acc  = ack && m_req;
      fire = upd && rate != 0 && (m_upd + 1 >= int'(rate));
      e.done = acc && m_srv;
      if (ack && !m_req) m_err = 1;
      want = !m_req && (sw || m_swp || m_aup || fire);
      if (m_req && sw) m_swp = 1;
      if (acc) begin
        m_req = 0; m_srv = 0; m_aup = 0; m_upd = 0;
        if (m_cnt < CMAX) m_cnt++;
      end else if (fire) begin
        m_aup = 1; m_upd = 0;
      end else if (upd && rate != 0) m_upd++;
      if (want) begin
        m_req = 1; m_srv = sw || m_swp; m_swp = 0;
      end
    end
    e.req = m_req; e.busy = m_req || m_swp || m_aup; e.cnt = m_cnt; e.err = m_err;
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("reseed_req", int'(req_o), int'(mon_e.req));
        chk("busy", int'(busy_o), int'(mon_e.busy));
        chk("sw_done", int'(done_o), int'(mon_e.done));
        chk("reseed_cnt", int'(cnt_o), mon_e.cnt);
        chk("ack_err", int'(err_o), int'(mon_e.err));
      end
    end
  end

  initial begin
    rst = 1'b1; sw = 1'b0; upd = 1'b0; ack = 1'b0; rate = 16'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      step();
    end
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk); #1;
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 79) == 0) rate = CW'(rates[$urandom_range(0, 5)]);
      upd = ($urandom_range(0, 2) == 0);
      sw  = ($urandom_range(0, 24) == 0);
      ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 299) == 0);
      step();
    end
    @(negedge clk); #1;
    rst = 1'b0; sw = 1'b0; upd = 1'b0; ack = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
